// File: rtl/rom_load_pkg.sv
// Shared types and constants for the ROM download controller.
package rom_load_pkg;

   localparam int AW_DEFAULT = 25;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOADING,
      ST_CHECK,
      ST_HOLD,
      ST_RUN
   } state_t;

endpackage

// File: rtl/rgn_decode.sv
// Priority region select: picks the lowest region whose exclusive end lies
// above the address and returns the address relative to that region's base.
module rgn_decode
   import rom_load_pkg::*;
#(
   parameter int NREGIONS = 4,
   parameter int AW       = AW_DEFAULT
) (
   input  logic [AW-1:0]          addr_i,
   input  logic [NREGIONS*AW-1:0] region_end_i,
   output logic                   hit_o,
   output logic [NREGIONS-1:0]    sel_o,
   output logic [AW-1:0]          offset_o
);

   logic [AW-1:0] base;

   always_comb begin
      hit_o    = 1'b0;
      sel_o    = '0;
      offset_o = '0;
      base     = '0;
      for (int i = 0; i < NREGIONS; i++) begin
         if (!hit_o && (addr_i < region_end_i[i*AW +: AW])) begin
            hit_o    = 1'b1;
            sel_o[i] = 1'b1;
            offset_o = addr_i - base;
         end
         // region i+1 starts where region i ends
         base = region_end_i[i*AW +: AW];
      end
   end

endmodule

// File: rtl/rom_load_ctrl.sv
// ROM download sequencer: routes data_io bytes into regions, validates size,
// then stretches core reset. Optional checksum check via ROM_LOAD_CHECKSUM_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no valid ROM, core held in reset, waiting for a download
// LOADING | accepting ioctl_wr bytes into the regions
// CHECK   | one cycle: judge byte count (and checksum) of the load
// HOLD    | ROM valid, core reset stretched for RST_CYCLES cycles
// RUN     | core released from reset
module rom_load_ctrl
   import rom_load_pkg::*;
#(
   parameter int         NREGIONS   = 4,
   parameter int         AW         = AW_DEFAULT,
   parameter logic [7:0] ROM_INDEX  = 8'd0,
   parameter int         RST_CYCLES = 256,
   parameter logic [7:0] EXP_SUM    = 8'h00
) (
   input  logic                   clk_sys,
   input  logic                   reset,
   input  logic                   user_reset,
   input  logic                   ioctl_download,
   input  logic [7:0]             ioctl_index,
   input  logic                   ioctl_wr,
   input  logic [AW-1:0]          ioctl_addr,
   input  logic [7:0]             ioctl_dout,
   input  logic [NREGIONS*AW-1:0] region_end,
   output logic [NREGIONS-1:0]    rgn_we,
   output logic [AW-1:0]          rgn_addr,
   output logic [7:0]             rgn_data,
   output logic                   rom_loaded,
   output logic                   core_reset,
   output logic                   load_error,
   output logic [7:0]             checksum
);

   localparam int HCW = $clog2(RST_CYCLES + 1);

   state_t                state_q;
   logic                  dl_prev_q;
   logic [NREGIONS-1:0]   rgn_we_q;
   logic [AW-1:0]         rgn_addr_q;
   logic [7:0]            rgn_data_q;
   logic                  rom_loaded_q;
   logic                  core_reset_q;
   logic                  load_error_q;
   logic [AW:0]           bytes_q;
   logic [HCW-1:0]        hold_q;

   logic                  dec_hit_d;
   logic [NREGIONS-1:0]   dec_sel_d;
   logic [AW-1:0]         dec_off_d;
   logic [AW-1:0]         last_end;
   logic                  start_d;
   logic                  acc_wr_d;
   logic                  size_ok;
   logic                  sum_ok;

   rgn_decode #(
      .NREGIONS (NREGIONS),
      .AW       (AW)
   ) u_rgn_decode (
      .addr_i       (ioctl_addr),
      .region_end_i (region_end),
      .hit_o        (dec_hit_d),
      .sel_o        (dec_sel_d),
      .offset_o     (dec_off_d)
   );

   assign last_end = region_end[(NREGIONS-1)*AW +: AW];
   // edge-qualified so a download already in flight across a reset is ignored
   assign start_d  = ioctl_download && !dl_prev_q && (ioctl_index == ROM_INDEX)
                     && (state_q != ST_LOADING);
   assign acc_wr_d = (state_q == ST_LOADING) && ioctl_wr && dec_hit_d;
   assign size_ok  = (bytes_q >= {1'b0, last_end});

`ifdef ROM_LOAD_CHECKSUM_EN
   logic [7:0] sum_q;

   always_ff @(posedge clk_sys) begin
      if (reset || start_d) begin
         sum_q <= 8'h00;
      end else if (acc_wr_d) begin
         sum_q <= sum_q + ioctl_dout;
      end
   end

   assign checksum = sum_q;
   assign sum_ok   = (sum_q == EXP_SUM);
`else
   logic unused_exp_sum;

   assign unused_exp_sum = ^EXP_SUM;
   assign checksum       = 8'h00;
   assign sum_ok         = 1'b1;
`endif

   always_ff @(posedge clk_sys) begin
      dl_prev_q <= ioctl_download;
      if (reset) begin
         state_q      <= ST_IDLE;
         rgn_we_q     <= '0;
         rgn_addr_q   <= '0;
         rgn_data_q   <= 8'h00;
         rom_loaded_q <= 1'b0;
         core_reset_q <= 1'b1;
         load_error_q <= 1'b0;
         bytes_q      <= '0;
         hold_q       <= '0;
      end else begin
         rgn_we_q <= '0;
         if (start_d) begin
            state_q      <= ST_LOADING;
            rom_loaded_q <= 1'b0;
            load_error_q <= 1'b0;
            core_reset_q <= 1'b1;
            bytes_q      <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
               end
               ST_LOADING: begin
                  if (ioctl_wr) begin
                     if (dec_hit_d) begin
                        rgn_we_q   <= dec_sel_d;
                        rgn_addr_q <= dec_off_d;
                        rgn_data_q <= ioctl_dout;
                        if (bytes_q != '1) begin
                           bytes_q <= bytes_q + 1'b1;
                        end
                     end else begin
                        load_error_q <= 1'b1;
                     end
                  end
                  if (!ioctl_download) begin
                     state_q <= ST_CHECK;
                  end
               end
               ST_CHECK: begin
                  if (!size_ok) begin
                     load_error_q <= 1'b1;
                     state_q      <= ST_IDLE;
                  end else begin
                     rom_loaded_q <= 1'b1;
                     if (!sum_ok) begin
                        load_error_q <= 1'b1;
                     end
                     hold_q  <= HCW'(RST_CYCLES - 1);
                     state_q <= ST_HOLD;
                  end
               end
               ST_HOLD: begin
                  // a held user_reset keeps reloading; the count starts once it drops
                  if (user_reset) begin
                     hold_q <= HCW'(RST_CYCLES);
                  end else if (hold_q == '0) begin
                     state_q      <= ST_RUN;
                     core_reset_q <= 1'b0;
                  end else begin
                     hold_q <= hold_q - 1'b1;
                  end
               end
               ST_RUN: begin
                  if (user_reset) begin
                     hold_q       <= HCW'(RST_CYCLES);
                     state_q      <= ST_HOLD;
                     core_reset_q <= 1'b1;
                  end
               end
               default: begin
                  state_q      <= ST_IDLE;
                  core_reset_q <= 1'b1;
               end
            endcase
         end
      end
   end

   assign rgn_we     = rgn_we_q;
   assign rgn_addr   = rgn_addr_q;
   assign rgn_data   = rgn_data_q;
   assign rom_loaded = rom_loaded_q;
   assign core_reset = core_reset_q;
   assign load_error = load_error_q;

endmodule

// File: tb/tb_rom_load_ctrl.sv
// Directed-sequence bench with random data/addresses and a small reference model.
`timescale 1ns/1ps
module tb_rom_load_ctrl;

   localparam int NR   = 2;
   localparam int AW   = 25;
   localparam int RSTC = 16;
   localparam logic [AW-1:0] END0 = 25'h4000;
   localparam logic [AW-1:0] END1 = 25'h6000;

   logic clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   logic             reset, user_reset, ioctl_download, ioctl_wr;
   logic [7:0]       ioctl_index, ioctl_dout;
   logic [AW-1:0]    ioctl_addr;
   logic [NR*AW-1:0] region_end;
   logic [NR-1:0]    rgn_we;
   logic [AW-1:0]    rgn_addr;
   logic [7:0]       rgn_data, checksum;
   logic             rom_loaded, core_reset, load_error;

   assign region_end = {END1, END0};

   rom_load_ctrl #(
      .NREGIONS   (NR),
      .AW         (AW),
      .ROM_INDEX  (8'd0),
      .RST_CYCLES (RSTC),
      .EXP_SUM    (8'h00)
   ) dut (
      .clk_sys        (clk_sys),
      .reset          (reset),
      .user_reset     (user_reset),
      .ioctl_download (ioctl_download),
      .ioctl_index    (ioctl_index),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .region_end     (region_end),
      .rgn_we         (rgn_we),
      .rgn_addr       (rgn_addr),
      .rgn_data       (rgn_data),
      .rom_loaded     (rom_loaded),
      .core_reset     (core_reset),
      .load_error     (load_error),
      .checksum       (checksum)
   );

   int checks = 0;
   int errors = 0;

   int            stream_bad, r0_cnt, r1_cnt;
   logic [AW-1:0] r0_max, r1_max;
   logic [NR-1:0] exp_we;
   logic [AW-1:0] exp_addr;
   logic [7:0]    exp_data;
   int            mdl_bytes;
   bit            mdl_err;
   logic [7:0]    mdl_sum;
   bit            dl_v, rst_v, ur_v;
   logic [7:0]    idx_v;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_stats();
      stream_bad = 0;
      r0_cnt     = 0;
      r1_cnt     = 0;
      r0_max     = '0;
      r1_max     = '0;
   endtask

   // One clock: check the strobe due from last cycle's write, then drive this cycle.
   task automatic step(input bit wr, input logic [AW-1:0] a, input bit acc);
      logic [7:0] d;
      @(posedge clk_sys);
      #1;
      if (rgn_we !== exp_we) stream_bad++;
      else if (exp_we != '0 && (rgn_addr !== exp_addr || rgn_data !== exp_data)) stream_bad++;
      if (rgn_we === 2'b01) begin
         r0_cnt++;
         if (rgn_addr > r0_max) r0_max = rgn_addr;
      end
      if (rgn_we === 2'b10) begin
         r1_cnt++;
         if (rgn_addr > r1_max) r1_max = rgn_addr;
      end
      d              = 8'($urandom);
      reset          = rst_v;
      user_reset     = ur_v;
      ioctl_download = dl_v;
      ioctl_index    = idx_v;
      ioctl_wr       = wr;
      ioctl_addr     = a;
      ioctl_dout     = d;
      exp_we         = '0;
      if (wr && acc && !rst_v) begin
         if (a < END1) begin
            mdl_bytes++;
            mdl_sum  = mdl_sum + d;
            exp_data = d;
            if (a < END0) begin
               exp_we   = 2'b01;
               exp_addr = a;
            end else begin
               exp_we   = 2'b10;
               exp_addr = a - END0;
            end
         end else begin
            mdl_err = 1'b1;
         end
      end
   endtask

   task automatic begin_load(input logic [7:0] idx);
      dl_v  = 1'b1;
      idx_v = idx;
      if (idx == 8'd0) begin
         mdl_bytes = 0;
         mdl_err   = 1'b0;
         mdl_sum   = 8'h00;
      end
      clr_stats();
      step(1'b0, '0, 1'b0);
      step(1'b0, '0, 1'b0);
   endtask

   function automatic logic exp_loaded();
      return (mdl_bytes >= int'(END1));
   endfunction

   function automatic logic exp_error();
      logic e;
      e = mdl_err || !exp_loaded();
`ifdef ROM_LOAD_CHECKSUM_EN
      if (exp_loaded() && mdl_sum != 8'h00) e = 1'b1;
`endif
      return e;
   endfunction

   function automatic logic [7:0] exp_cks();
`ifdef ROM_LOAD_CHECKSUM_EN
      return mdl_sum;
`else
      return 8'h00;
`endif
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int bad;
      rst_v = 1'b1; ur_v = 1'b0; dl_v = 1'b0; idx_v = 8'd0;
      reset = 1'b1; user_reset = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0;
      ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_dout = 8'h00;
      exp_we = '0; exp_addr = '0; exp_data = 8'h00;
      mdl_bytes = 0; mdl_err = 1'b0; mdl_sum = 8'h00;
      clr_stats();

      // reset values
      repeat (3) step(1'b0, '0, 1'b0);
      rst_v = 1'b0;
      step(1'b0, '0, 1'b0);
      chk("rst_we", 32'(rgn_we), 0);
      chk("rst_addr", rgn_addr, 0);
      chk("rst_data", rgn_data, 0);
      chk("rst_loaded", rom_loaded, 0);
      chk("rst_core_reset", core_reset, 1);
      chk("rst_error", load_error, 0);
      chk("rst_checksum", checksum, 0);

      // full sequential load with random gaps; last byte on the download fall
      begin_load(8'd0);
      for (int a = 0; a < 'h5FFF; a++) begin
         if ($urandom_range(0, 15) == 0) step(1'b0, '0, 1'b1);
         step(1'b1, AW'(a), 1'b1);
      end
      dl_v = 1'b0;
      step(1'b1, 25'h5FFF, 1'b1);
      bad = 0;
      for (int k = 1; k <= 18; k++) begin
         step(1'b0, '0, 1'b0);
         if (k <= 17 && core_reset !== 1'b1) bad++;
         if (k == 18) chk("A_core_reset_fall", core_reset, 0);
      end
      chk("A_core_reset_hold", bad, 0);
      chk("A_stream", stream_bad, 0);
      chk("A_r0_count", r0_cnt, 'h4000);
      chk("A_r1_count", r1_cnt, 'h2000);
      chk("A_r0_max", r0_max, 'h3FFF);
      chk("A_r1_max", r1_max, 'h1FFF);
      chk("A_loaded", rom_loaded, 32'(exp_loaded()));
      chk("A_error", load_error, 32'(exp_error()));
      chk("A_checksum", checksum, 32'(exp_cks()));

      // foreign-index download while running
      begin_load(8'd1);
      bad = 0;
      for (int i = 0; i < 24; i++) begin
         step(1'b1, AW'($urandom_range(0, 'h7FFF)), 1'b0);
         if (core_reset !== 1'b0 || rom_loaded !== 1'b1) bad++;
      end
      dl_v = 1'b0;
      repeat (4) begin
         step(1'b0, '0, 1'b0);
         if (core_reset !== 1'b0 || rom_loaded !== 1'b1) bad++;
      end
      idx_v = 8'd0;
      chk("B_no_we", stream_bad + r0_cnt + r1_cnt, 0);
      chk("B_run_undisturbed", bad, 0);

      // 3-cycle user_reset pulse in RUN
      ur_v = 1'b1;
      repeat (3) step(1'b0, '0, 1'b0);
      chk("C_core_reset_rise", core_reset, 1);
      ur_v = 1'b0;
      step(1'b0, '0, 1'b0);
      bad = 0;
      for (int k = 1; k <= 17; k++) begin
         step(1'b0, '0, 1'b0);
         if (k <= 16 && core_reset !== 1'b1) bad++;
         if (k == 17) chk("C_core_reset_fall", core_reset, 0);
      end
      chk("C_core_reset_hold", bad, 0);

      // reload from RUN: random in-range addresses plus out-of-range writes
      begin_load(8'd0);
      chk("D_start_clears", {rom_loaded, core_reset, load_error}, 3'b010);
      for (int i = 0; i < 'h6000; i++) begin
         if (i == 'h1000) step(1'b1, END1, 1'b1);
         if (i == 'h3000) step(1'b1, END1 + AW'($urandom_range(1, 'h1000)), 1'b1);
         step(1'b1, AW'($urandom_range(0, 'h5FFF)), 1'b1);
         if (i == 'h1002) chk("D_error_sticky", load_error, 32'(mdl_err));
      end
      dl_v = 1'b0;
      step(1'b0, '0, 1'b0);
      repeat (2) step(1'b0, '0, 1'b0);
      chk("D_stream", stream_bad, 0);
      chk("D_loaded", rom_loaded, 32'(exp_loaded()));
      chk("D_error", load_error, 32'(exp_error()));
      repeat (20) step(1'b0, '0, 1'b0);

      // short download: size check fails
      begin_load(8'd0);
      for (int a = 0; a < 'h4FFF; a++) step(1'b1, AW'(a), 1'b1);
      dl_v = 1'b0;
      step(1'b1, 25'h4FFF, 1'b1);
      repeat (2) step(1'b0, '0, 1'b0);
      chk("E_loaded", rom_loaded, 32'(exp_loaded()));
      chk("E_error", load_error, 32'(exp_error()));
      bad = 0;
      repeat (40) begin
         step(1'b0, '0, 1'b0);
         if (core_reset !== 1'b1) bad++;
      end
      chk("E_core_reset_held", bad, 0);
      chk("E_stream", stream_bad, 0);
      chk("E_counts", {r0_cnt[15:0], r1_cnt[15:0]}, {16'h4000, 16'h1000});

      // reset in the middle of a download
      begin_load(8'd0);
      for (int a = 0; a < 'h100; a++) step(1'b1, AW'(a), 1'b1);
      rst_v = 1'b1;
      step(1'b1, 25'h100, 1'b0);
      step(1'b1, 25'h101, 1'b0);
      rst_v = 1'b0;
      step(1'b1, 25'h102, 1'b0);
      chk("F_rst_outputs", {rgn_we, rgn_addr, rgn_data}, '0);
      chk("F_rst_flags", {rom_loaded, core_reset, load_error, checksum}, 11'h200);
      for (int a = 'h103; a < 'h140; a++) step(1'b1, AW'(a), 1'b0);
      dl_v = 1'b0;
      repeat (5) step(1'b0, '0, 1'b0);
      chk("F_stream", stream_bad, 0);
      chk("F_r0_count", r0_cnt, 'h100);
      chk("F_idle_flags", {rom_loaded, core_reset, load_error}, 3'b010);
      begin_load(8'd0);
      for (int a = 0; a < 'h10; a++) step(1'b1, AW'(a), 1'b1);
      dl_v = 1'b0;
      repeat (4) step(1'b0, '0, 1'b0);
      chk("F_reload_stream", stream_bad, 0);
      chk("F_reload_count", r0_cnt, 'h10);
      chk("F_reload_error", load_error, 32'(exp_error()));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
